// File: rtl/wptr_full_level.sv
// rtl/wptr_full_level.sv - write-domain pointer, full, level and overflow flags for an async FIFO
//
// Purpose:
//   Generates the binary write address and Gray write pointer for the write side of
//   an async FIFO. Writes are accepted only while not full. Also produces a registered
//   write-side fill level, a programmable almost-full flag and a sticky overflow flag.
//
// Optional feature macro: WPTR_WRCOUNT_EN
//   When defined, adds wr_count, a saturating count of accepted writes.
//   wr_count is cleared by reset and by ovf_clr.
//
// Ports:
//   wclk          in   1            write clock
//   wrst_n        in   1            async active-low reset, write domain
//   winc          in   1            write request, accepted only when wfull==0
//   wq2_rptr      in   ADDRSIZE+1   Gray read pointer, synchronised into wclk
//   afull_thresh  in   ADDRSIZE+1   almost-full threshold in entries (quasi-static)
//   ovf_clr       in   1            clears wovf (and wr_count when enabled)
//   waddr         out  ADDRSIZE     binary memory write address
//   wptr          out  ADDRSIZE+1   registered Gray write pointer
//   wfull         out  1            FIFO full, registered
//   walmost_full  out  1            fill level >= afull_thresh, registered
//   wlevel        out  ADDRSIZE+1   write-side fill level 0..DEPTH, registered
//   wovf          out  1            sticky: write attempted while full
//   wr_count      out  32           accepted-write count (WPTR_WRCOUNT_EN only)

module wptr_full_level #(
  parameter int ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic                ovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
`ifdef WPTR_WRCOUNT_EN
  output logic [31:0]         wr_count,
`endif
  output logic                wovf
);

  localparam logic [ADDRSIZE:0] DEPTH_W = {1'b1, {ADDRSIZE{1'b0}}};

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              wfull_q, wfull_d;
  logic              walmost_full_q, walmost_full_d;
  logic              wovf_q, wovf_d;

  logic              accept;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] full_cmp;

  assign accept = winc & ~wfull_q;

  // Gray-to-binary of the synchronised read pointer: each binary bit is the XOR
  // of all Gray bits from the MSB down to that position.
  always_comb begin
    rbin = '0;
    rbin[ADDRSIZE] = wq2_rptr[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ wq2_rptr[i];
    end
  end

  // Classic Gray full test: write pointer equals read pointer with the two MSBs
  // inverted. This is equivalent to (level == DEPTH) for a one-bit-per-cycle read
  // pointer. It is used directly because it avoids the subtractor on the full path.
  always_comb begin
    full_cmp = wq2_rptr;
    full_cmp[ADDRSIZE]   = ~wq2_rptr[ADDRSIZE];
    full_cmp[ADDRSIZE-1] = ~wq2_rptr[ADDRSIZE-1];
  end

  always_comb begin
    wbin_d         = wbin_q + {{ADDRSIZE{1'b0}}, accept};
    wptr_d         = (wbin_d >> 1) ^ wbin_d;
    // Modulo subtraction stays within 0..DEPTH.
    // The read pointer lags, so this never under-reports occupancy.
    wlevel_d       = wbin_d - rbin;
    wfull_d        = (wptr_d == full_cmp);
    // A threshold above DEPTH can never be reached, so no special case is needed.
    walmost_full_d = (wlevel_d >= afull_thresh);
    wovf_d         = wovf_q;
    if (ovf_clr) begin
      wovf_d = 1'b0;
    end else if (winc && wfull_q) begin
      wovf_d = 1'b1;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wovf_q         <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wovf_q         <= wovf_d;
    end
  end

`ifdef WPTR_WRCOUNT_EN
  logic [31:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (ovf_clr) begin
      wr_count_d = '0;
    end else if (accept && (wr_count_q != 32'hFFFF_FFFF)) begin
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;
`endif

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// tb/tb_wptr_full_level.sv - directed self-checking bench for wptr_full_level (ADDRSIZE=4)

module tb_wptr_full_level;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [4:0] wq2_rptr = '0;
  logic [4:0] afull_thresh = 5'd0;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       wovf;
`ifdef WPTR_WRCOUNT_EN
  logic [31:0] wr_count;
`endif

  int checks = 0;
  int errors = 0;

  wptr_full_level #(.ADDRSIZE(4)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .afull_thresh (afull_thresh),
    .ovf_clr      (ovf_clr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
`ifdef WPTR_WRCOUNT_EN
    .wr_count     (wr_count),
`endif
    .wovf         (wovf)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [4:0] gray(input int b);
    logic [4:0] x;
    x = 5'(b);
    return (x >> 1) ^ x;
  endfunction

  initial begin
    // Reset state
    repeat (2) step();
    check("rst_waddr", 32'(waddr), 0);
    check("rst_wptr", 32'(wptr), 0);
    check("rst_wfull", 32'(wfull), 0);
    check("rst_walmost", 32'(walmost_full), 0);
    check("rst_wlevel", 32'(wlevel), 0);
    check("rst_wovf", 32'(wovf), 0);

    // Threshold 0: almost-full from the first edge after release
    wrst_n = 1'b1;
    step();
    check("thr0_walmost", 32'(walmost_full), 1);
    check("thr0_wlevel", 32'(wlevel), 0);
    afull_thresh = 5'd12;

    // Reset mid-fill at level 7
    winc = 1'b1;
    repeat (7) step();
    check("fill7_wlevel", 32'(wlevel), 7);
    check("fill7_waddr", 32'(waddr), 7);
    check("fill7_wptr", 32'(wptr), 32'(gray(7)));
    wrst_n = 1'b0;
    #2;
    check("midrst_waddr", 32'(waddr), 0);
    check("midrst_wptr", 32'(wptr), 0);
    check("midrst_wlevel", 32'(wlevel), 0);
    check("midrst_wfull", 32'(wfull), 0);
    check("midrst_walmost", 32'(walmost_full), 0);
    winc = 1'b0;
    #1;
    wrst_n = 1'b1;
    step();
    check("post_rst_wptr", 32'(wptr), 0);
    check("post_rst_wlevel", 32'(wlevel), 0);

    // 16 back-to-back writes with read pointer at 0
    winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 11) begin
        check("afull_11", 32'(walmost_full), 0);
      end
      if (i == 12) begin
        check("afull_12", 32'(walmost_full), 1);
        check("lvl_12", 32'(wlevel), 12);
      end
      if (i == 15) begin
        check("notfull_15", 32'(wfull), 0);
      end
    end
    check("full_wfull", 32'(wfull), 1);
    check("full_wlevel", 32'(wlevel), 16);
    check("full_waddr", 32'(waddr), 0);
    check("full_wptr", 32'(wptr), 32'h18);

    // 3 extra writes while full
    repeat (3) step();
    check("ovf_wovf", 32'(wovf), 1);
    check("ovf_wptr", 32'(wptr), 32'h18);
    check("ovf_wlevel", 32'(wlevel), 16);
    check("ovf_waddr", 32'(waddr), 0);
    check("ovf_wfull", 32'(wfull), 1);

    winc = 1'b0;
    ovf_clr = 1'b1;
    step();
    check("ovfclr_wovf", 32'(wovf), 0);
    winc = 1'b1;
    step();
    check("ovfclr_wins", 32'(wovf), 0);
    ovf_clr = 1'b0;
    winc = 1'b0;

    // Read pointer steps 0->1 while full
    wq2_rptr = gray(1);
    step();
    check("rd1_wfull", 32'(wfull), 0);
    check("rd1_wlevel", 32'(wlevel), 15);
    check("rd1_walmost", 32'(walmost_full), 1);
    winc = 1'b1;
    step();
    check("refill_wfull", 32'(wfull), 1);
    check("refill_wlevel", 32'(wlevel), 16);
    check("refill_waddr", 32'(waddr), 1);
    check("refill_wptr", 32'(wptr), 32'h19);

    // Full and a read in the same cycle: write rejected
    wq2_rptr = gray(2);
    step();
    check("same_wfull", 32'(wfull), 0);
    check("same_wlevel", 32'(wlevel), 15);
    check("same_waddr", 32'(waddr), 1);
    check("same_wovf", 32'(wovf), 1);
    step();
    check("same2_wfull", 32'(wfull), 1);
    check("same2_wlevel", 32'(wlevel), 16);
    check("same2_waddr", 32'(waddr), 2);
    winc = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;

    // Drain to the almost-full threshold and below it
    for (int k = 3; k <= 6; k++) begin
      wq2_rptr = gray(k);
      step();
    end
    check("drain12_wlevel", 32'(wlevel), 12);
    check("drain12_walmost", 32'(walmost_full), 1);
    wq2_rptr = gray(7);
    step();
    check("drain11_wlevel", 32'(wlevel), 11);
    check("drain11_walmost", 32'(walmost_full), 0);

    // Threshold above DEPTH: never asserted, even when full
    afull_thresh = 5'd17;
    winc = 1'b1;
    repeat (5) step();
    check("thr17_wfull", 32'(wfull), 1);
    check("thr17_wlevel", 32'(wlevel), 16);
    check("thr17_walmost", 32'(walmost_full), 0);
    winc = 1'b0;

    // 40 writes with matching read advances, wrapping the pointer
    wrst_n = 1'b0;
    afull_thresh = 5'd12;
    wq2_rptr = '0;
    step();
    wrst_n = 1'b1;
    winc = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wq2_rptr = gray(i);
      step();
      check($sformatf("wrap_lvl_%0d", i), 32'(wlevel), 1);
      check($sformatf("wrap_full_%0d", i), 32'(wfull), 0);
    end
    winc = 1'b0;
    check("wrap_waddr", 32'(waddr), 8);
    check("wrap_wptr", 32'(wptr), 32'h0C);
`ifdef WPTR_WRCOUNT_EN
    check("wrap_wr_count", wr_count, 40);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
